hazard_scoreboard: RTL

- Parametrised successor to the fixed 5-stage forwarding/hazard logic.
- Keeps an internal shadow pipeline of destination info for the EX, MEM and WB stages.
- Decides load-use stalls, branch flushes and global freezes from that shadow pipeline.
- Registers per-operand forwarding selects so they are valid during the consumer's EX cycle, and keeps saturating stall/flush event counters.
- Sits between the decode stage and the datapath pipeline registers.

---
 rtl/hazard_scoreboard.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: shadow EX/MEM/WB destination pipeline that
// drives load-use stalls, branch flushes, forward selects and counters.
module hazard_scoreboard #(
  parameter int REG_W      = 5,
  parameter int LOAD_DELAY = 1,
  parameter int RF_BYPASS  = 1,
  parameter int ZERO_REG   = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             br_taken,
  input  logic             mem_busy,
  output logic             stall,
  output logic             pcwrite,
  output logic             ifidwrite,
  output logic             flush,
  output logic [1:0]       fw_a,
  output logic [1:0]       fw_b,
  output logic             ex_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic             v;
    logic             rw;
    logic             mr;
    logic [REG_W-1:0] rd;
  } ent_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  ent_t e1_q, e1_d;
  ent_t e2_q, e2_d;
  ent_t e3_q, e3_d;
  logic [1:0] fwa_q, fwa_d;
  logic [1:0] fwb_q, fwb_d;
  logic [CNT_W-1:0] sc_q, sc_d;
  logic [CNT_W-1:0] fc_q, fc_d;

  logic hz_rs;
  logic hz_rt;
  logic stall_raw;
  logic flush_raw;

  function automatic logic writes(ent_t e, logic [REG_W-1:0] r);
    logic is_zero;
    is_zero = (ZERO_REG != 0) && (r == '0);
    return e.v && e.rw && (e.rd == r) && !is_zero;
  endfunction

  function automatic logic load_hz(ent_t a, ent_t b,
                                   logic [REG_W-1:0] r);
    logic h;
    h = writes(a, r) && a.mr;
    if (LOAD_DELAY == 2)
      h = h || (writes(b, r) && b.mr);
    return h;
  endfunction

  function automatic logic [1:0] fw_sel(ent_t a, ent_t b, ent_t c,
                                        logic [REG_W-1:0] r);
    if (writes(a, r))
      return 2'b01;
    else if (writes(b, r))
      return 2'b10;
    else if ((RF_BYPASS == 0) && writes(c, r))
      return 2'b11;
    else
      return 2'b00;
  endfunction

  // Load-use detection and raw stall/flush decisions from the shadow pipe
  always_comb begin
    hz_rs = 1'b0;
    hz_rt = 1'b0;
    if (id_use_rs)
      hz_rs = load_hz(e1_q, e2_q, id_rs);
    if (id_use_rt)
      hz_rt = load_hz(e1_q, e2_q, id_rt);
    stall_raw = id_valid && (hz_rs || hz_rt);
    flush_raw = br_taken && id_valid && !stall_raw;
  end

  // Next shadow entries, forward selects and saturating counters
  always_comb begin
    e1_d  = e1_q;
    e2_d  = e2_q;
    e3_d  = e3_q;
    fwa_d = fwa_q;
    fwb_d = fwb_q;
    sc_d  = sc_q;
    fc_d  = fc_q;
    if (!mem_busy) begin
      e3_d = e2_q;
      e2_d = e1_q;
      if (stall_raw) begin
        e1_d = '0;
      end else begin
        e1_d.v  = id_valid;
        e1_d.rw = id_regwrite;
        e1_d.mr = id_memread;
        e1_d.rd = id_rd;
      end
      fwa_d = 2'b00;
      fwb_d = 2'b00;
      if (id_valid && !stall_raw && id_use_rs)
        fwa_d = fw_sel(e1_q, e2_q, e3_q, id_rs);
      if (id_valid && !stall_raw && id_use_rt)
        fwb_d = fw_sel(e1_q, e2_q, e3_q, id_rt);
      if (stall_raw && (sc_q != '1))
        sc_d = sc_q + CNT_ONE;
      if (flush_raw && (fc_q != '1))
        fc_d = fc_q + CNT_ONE;
    end
  end

  // State register with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e1_q  <= '0;
      e2_q  <= '0;
      e3_q  <= '0;
      fwa_q <= 2'b00;
      fwb_q <= 2'b00;
      sc_q  <= '0;
      fc_q  <= '0;
    end else begin
      e1_q  <= e1_d;
      e2_q  <= e2_d;
      e3_q  <= e3_d;
      fwa_q <= fwa_d;
      fwb_q <= fwb_d;
      sc_q  <= sc_d;
      fc_q  <= fc_d;
    end
  end

  assign stall     = stall_raw && !mem_busy;
  assign flush     = flush_raw && !mem_busy;
  assign pcwrite   = !stall && !mem_busy;
  assign ifidwrite = !stall && !mem_busy;
  assign fw_a      = fwa_q;
  assign fw_b      = fwb_q;
  assign ex_valid  = e1_q.v;
  assign stall_cnt = sc_q;
  assign flush_cnt = fc_q;

  // A load sitting in MEM is never the source of an EX/MEM forward
  a_no_load_fwd: assert property (@(posedge clk) disable iff (rst)
    ((fwa_q == 2'b01) || (fwb_q == 2'b01)) |-> !e2_q.mr);

endmodule
